// File: rtl/mm_pkg.sv
// Shared constants and drain FSM encoding for the accumulator result path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default accumulator/output widths, bank depth, address width, FSM states.
package mm_pkg;

  localparam int ACC_W   = 80;
  localparam int OUT_W   = 64;
  localparam int NUM_ADR = 4;
  localparam int ADR_W   = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_LATCH     = 3'd2,
    S_EMIT_EVEN = 3'd3,
    S_EMIT_ODD  = 3'd4,
    S_CLEAR     = 3'd5,
    S_FIN       = 3'd6
  } drain_state_t;

endpackage

// File: rtl/sat_narrow.sv
// Signed saturating narrow from an ACC_W accumulator word to OUT_W bits.
// Latency: combinational.
// Backpressure: none (pure function of acc).
// Ports: acc (wide signed input), res (narrowed/clamped value), sat (clamp applied).
module sat_narrow #(
  parameter int ACC_W = 80,
  parameter int OUT_W = 64
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] res,
  output logic             sat
);

  // The value fits when every bit from the MSB down to the output sign
  // position is a copy of the sign.
  logic [ACC_W-OUT_W:0] top;
  logic                 fits;

  assign top  = acc[ACC_W-1:OUT_W-1];
  assign fits = (&top) | ~(|top);

  always_comb begin
    res = acc[OUT_W-1:0];
    sat = 1'b0;
    if (!fits) begin
      sat = 1'b1;
      res = acc[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/result_drain.sv
// Drains both accumulator banks address by address, saturating each word and clearing as it goes.
// Latency: first out_valid 3 cycles after start; 5 cycles per address with out_ready held high, plus FIN.
// Backpressure: out_valid/out_ready; the FSM holds in EMIT_* and the latched words keep out_* stable.
// Ports: start -> busy/done; rdadr + even_q/odd_q (1-cycle read RAMs); clr_wradr/clr_en zero both banks;
//        out_data/out_sat/out_last/out_valid/out_ready result stream.
module result_drain #(
  parameter int ACC_W   = mm_pkg::ACC_W,
  parameter int OUT_W   = mm_pkg::OUT_W,
  parameter int NUM_ADR = mm_pkg::NUM_ADR
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ACC_W-1:0]         even_q,
  input  logic [ACC_W-1:0]         odd_q,
  output logic [mm_pkg::ADR_W-1:0] rdadr,
  output logic [mm_pkg::ADR_W-1:0] clr_wradr,
  output logic                     clr_en,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sat,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int                     ADR_W    = mm_pkg::ADR_W;
  localparam logic [ADR_W-1:0]       LAST_ADR = ADR_W'(NUM_ADR - 1);

  mm_pkg::drain_state_t state, state_nxt;
  logic [ADR_W-1:0]     cnt, cnt_nxt;
  logic [ACC_W-1:0]     even_r, odd_r;
  logic                 sel_odd;
  logic [ACC_W-1:0]     sat_in;
  logic [OUT_W-1:0]     sat_res;
  logic                 sat_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= mm_pkg::S_IDLE;
      cnt    <= '0;
      even_r <= '0;
      odd_r  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      // Read data returns one cycle after rdadr, i.e. during LATCH.
      if (state == mm_pkg::S_LATCH) begin
        even_r <= even_q;
        odd_r  <= odd_q;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_valid = 1'b0;
    sel_odd   = 1'b0;
    clr_en    = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    unique case (state)
      mm_pkg::S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = mm_pkg::S_READ;
          cnt_nxt   = '0;
        end
      end
      mm_pkg::S_READ:  state_nxt = mm_pkg::S_LATCH;
      mm_pkg::S_LATCH: state_nxt = mm_pkg::S_EMIT_EVEN;
      mm_pkg::S_EMIT_EVEN: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = mm_pkg::S_EMIT_ODD;
      end
      mm_pkg::S_EMIT_ODD: begin
        out_valid = 1'b1;
        sel_odd   = 1'b1;
        if (out_ready) state_nxt = mm_pkg::S_CLEAR;
      end
      mm_pkg::S_CLEAR: begin
        // Clear only after both words of this address have left, so a
        // stalled consumer never loses data.
        clr_en = 1'b1;
        if (cnt == LAST_ADR) begin
          state_nxt = mm_pkg::S_FIN;
        end else begin
          cnt_nxt   = cnt + 1'b1;
          state_nxt = mm_pkg::S_READ;
        end
      end
      mm_pkg::S_FIN: begin
        done      = 1'b1;
        state_nxt = mm_pkg::S_IDLE;
      end
      default: state_nxt = mm_pkg::S_IDLE;
    endcase
  end

  // One saturator shared between the two latched words.
  assign sat_in = sel_odd ? odd_r : even_r;

  sat_narrow #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .acc (sat_in),
    .res (sat_res),
    .sat (sat_flag)
  );

  assign out_data  = out_valid ? sat_res : '0;
  assign out_sat   = out_valid & sat_flag;
  assign out_last  = sel_odd & (cnt == LAST_ADR);
  assign rdadr     = cnt;
  assign clr_wradr = cnt;

endmodule

// File: tb/tb_result_drain.sv
// Scoreboard bench for result_drain with a 1-cycle-latency RAM model for both banks.
module tb_result_drain;

  localparam int AW = mm_pkg::ACC_W;
  localparam int OW = mm_pkg::OUT_W;
  localparam int NA = mm_pkg::NUM_ADR;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic [AW-1:0]            even_q, odd_q;
  logic [mm_pkg::ADR_W-1:0] rdadr, clr_wradr;
  logic                     clr_en;
  logic [OW-1:0]            out_data;
  logic                     out_valid, out_ready, out_sat, out_last, busy, done;

  always #5 clk = ~clk;

  result_drain #(.ACC_W(AW), .OUT_W(OW), .NUM_ADR(NA)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .even_q    (even_q),
    .odd_q     (odd_q),
    .rdadr     (rdadr),
    .clr_wradr (clr_wradr),
    .clr_en    (clr_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sat   (out_sat),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // Bank model: registered read, write-zero on clr_en.
  logic [AW-1:0] even_mem [NA];
  logic [AW-1:0] odd_mem  [NA];

  always @(posedge clk) begin
    even_q <= even_mem[rdadr];
    odd_q  <= odd_mem[rdadr];
    if (clr_en) begin
      even_mem[clr_wradr] = '0;
      odd_mem[clr_wradr]  = '0;
    end
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Scoreboard queues: {data, sat, last} per word, and clear addresses.
  logic [OW+1:0] exp_q[$];
  int            clr_exp_q[$];
  int            xfer_cnt = 0;
  int            clr_cnt  = 0;
  int            done_cnt = 0;
  logic          stall_prev = 1'b0;
  logic [OW+1:0] held = '0;
  logic          last_clr_prev = 1'b0;

  always @(negedge clk) begin
    logic [OW+1:0] e;
    int            a;
    if (rst) begin
      stall_prev    = 1'b0;
      last_clr_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid)
        chk("hold_stable", AW'({out_data, out_sat, out_last}), AW'(held));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", AW'(1), AW'(0));
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("word%0d", xfer_cnt), AW'({out_data, out_sat, out_last}), AW'(e));
        end
        xfer_cnt++;
      end
      stall_prev = out_valid && !out_ready;
      held       = {out_data, out_sat, out_last};
      if (clr_en) begin
        if (clr_exp_q.size() == 0) begin
          chk("unexpected_clr", AW'(1), AW'(0));
        end else begin
          a = clr_exp_q.pop_front();
          chk("clr_adr", AW'(clr_wradr), AW'(a));
        end
        chk("clr_after_both_words", AW'(xfer_cnt), AW'(2 * (int'(clr_wradr) + 1)));
        clr_cnt++;
      end
      if (done) begin
        chk("done_after_last_clr", AW'(last_clr_prev), AW'(1));
        done_cnt++;
      end
      last_clr_prev = clr_en && (int'(clr_wradr) == NA - 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_w(input logic [OW-1:0] d, input logic s, input logic l);
    exp_q.push_back({d, s, l});
  endtask

  task automatic clear_counts();
    xfer_cnt = 0;
    clr_cnt  = 0;
    done_cnt = 0;
  endtask

  task automatic load_seq();
    for (int a = 0; a < NA; a++) begin
      even_mem[a] = AW'(2 * a + 1);
      odd_mem[a]  = AW'(2 * a + 2);
    end
  endtask

  task automatic push_seq();
    for (int k = 1; k <= 2 * NA; k++) push_w(OW'(k), 1'b0, k == 2 * NA);
    for (int a = 0; a < NA; a++) clr_exp_q.push_back(a);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out_valid"}, AW'(out_valid), AW'(0));
    chk({tag, "_out_data"},  AW'(out_data),  AW'(0));
    chk({tag, "_out_sat"},   AW'(out_sat),   AW'(0));
    chk({tag, "_out_last"},  AW'(out_last),  AW'(0));
    chk({tag, "_clr_en"},    AW'(clr_en),    AW'(0));
    chk({tag, "_busy"},      AW'(busy),      AW'(0));
    chk({tag, "_done"},      AW'(done),      AW'(0));
    chk({tag, "_rdadr"},     AW'(rdadr),     AW'(0));
    chk({tag, "_clr_wradr"}, AW'(clr_wradr), AW'(0));
  endtask

  task automatic kick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_done_seen"}, AW'(done), AW'(1));
    tick();
  endtask

  task automatic chk_end(input string tag, input int words, input int clrs, input int dones);
    chk({tag, "_words"},   AW'(xfer_cnt),         AW'(words));
    chk({tag, "_clrs"},    AW'(clr_cnt),          AW'(clrs));
    chk({tag, "_dones"},   AW'(done_cnt),         AW'(dones));
    chk({tag, "_exp_q"},   AW'(exp_q.size()),     AW'(0));
    chk({tag, "_clr_q"},   AW'(clr_exp_q.size()), AW'(0));
  endtask

  initial begin
    int   cyc;
    logic hit;
    logic any;

    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    for (int a = 0; a < NA; a++) begin
      even_mem[a] = '0;
      odd_mem[a]  = '0;
    end
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();

    // Single drain, values 1..8, ready always high.
    clear_counts();
    load_seq();
    push_seq();
    kick();
    cyc = 1;
    while (!out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("first_valid_latency", AW'(cyc), AW'(3));
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    chk("start_to_done_cycles", AW'(cyc), AW'(21));
    tick();
    chk_end("drain", 2 * NA, NA, 1);
    any = 1'b0;
    for (int a = 0; a < NA; a++) any = any | (|even_mem[a]) | (|odd_mem[a]);
    chk("banks_cleared", AW'(any), AW'(0));
    chk("idle_after_drain", AW'(busy), AW'(0));

    // Saturation corners.
    clear_counts();
    even_mem[0] = 80'h0001_0000_0000_0000_0000;
    odd_mem[0]  = 80'hFFFF_8000_0000_0000_0000;
    even_mem[1] = 80'hFF00_0000_0000_0000_0000;
    odd_mem[1]  = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    even_mem[2] = 80'h0000_7FFF_FFFF_FFFF_FFFF;
    odd_mem[2]  = 80'h0000_8000_0000_0000_0000;
    even_mem[3] = 80'h0000_0000_0000_0000_0000;
    odd_mem[3]  = 80'hFFFF_7FFF_FFFF_FFFF_FFFF;
    push_w(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    push_w(64'h8000_0000_0000_0000, 1'b0, 1'b0);
    push_w(64'h8000_0000_0000_0000, 1'b1, 1'b0);
    push_w(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    push_w(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    push_w(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    push_w(64'h0000_0000_0000_0000, 1'b0, 1'b0);
    push_w(64'h8000_0000_0000_0000, 1'b1, 1'b1);
    for (int a = 0; a < NA; a++) clr_exp_q.push_back(a);
    kick();
    wait_done("sat");
    chk_end("sat", 2 * NA, NA, 1);

    // Backpressure: stall 5 cycles while word 3 (even, address 1) is offered.
    clear_counts();
    load_seq();
    push_seq();
    kick();
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick();
      if (out_valid && xfer_cnt == 2) begin
        hit = 1'b1;
        out_ready = 1'b0;
        repeat (5) tick();
        chk("stall_word3_data", AW'(out_data), AW'(3));
        out_ready = 1'b1;
      end
    end
    chk("stall_point_reached", AW'(hit), AW'(1));
    wait_done("bp");
    chk_end("bp", 2 * NA, NA, 1);

    // Reset during the second EMIT_ODD: abort after address 0 was cleared.
    clear_counts();
    load_seq();
    for (int k = 1; k <= 3; k++) push_w(OW'(k), 1'b0, 1'b0);
    clr_exp_q.push_back(0);
    kick();
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick();
      if (out_valid && xfer_cnt == 3) begin
        hit       = 1'b1;
        rst       = 1'b1;
        out_ready = 1'b0;
      end
    end
    chk("abort_point_reached", AW'(hit), AW'(1));
    tick();
    chk_idle("abort");
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (30) tick();
    chk_end("abort", 3, 1, 0);
    chk("abort_even0_cleared", even_mem[0], AW'(0));
    chk("abort_odd0_cleared",  odd_mem[0],  AW'(0));
    chk("abort_even1_kept",    even_mem[1], AW'(3));
    chk("abort_odd1_kept",     odd_mem[1],  AW'(4));

    // start with rst in the same cycle, then start while busy.
    clear_counts();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    tick();
    chk("start_with_rst_ignored", AW'(busy), AW'(0));
    load_seq();
    push_seq();
    kick();
    repeat (5) tick();
    kick();
    wait_done("busy_start");
    repeat (6) tick();
    chk("no_second_drain", AW'(busy), AW'(0));
    chk_end("busy_start", 2 * NA, NA, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
